// File: rtl/osc_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// osc_clk_rst_sequencer
//
// Purpose:
//   Qualifies the oscillator-derived fabric clock tree before letting logic
//   run. It holds every downstream reset domain until the oscillator has had
//   SETTLE_CYCLES to warm up and CCC lock plus system INIT_DONE have both been
//   stable for LOCK_FILTER consecutive cycles. It then releases the domains one
//   at a time, STAGGER_CYCLES apart, lowest index first. A lock loss or a
//   forced reset re-asserts every domain, holds them for at least HOLD_CYCLES,
//   and then repeats qualification.
//
// Ports:
//   CLK             fabric clock (oscillator derived)
//   RESET_N         asynchronous active-low reset
//   CCC_LOCK        CCC lock, asynchronous, synchronized internally (2 FF)
//   INIT_DONE       system init complete, asynchronous, synchronized (2 FF)
//   FORCE_RESET     synchronous single-cycle request to re-run the sequence
//   DOMAIN_RESET_N  per-domain active-low resets, bit 0 released first
//   CLK_GOOD        high only while all domains are running
//   STATE           current state: 0 SETTLE, 1 WAIT_LOCK, 2 RELEASE,
//                   3 RUN, 4 FAULT_HOLD
//   LOCK_LOSS_CNT   saturating count of lock-loss events
// -----------------------------------------------------------------------------
module osc_clk_rst_sequencer #(
   parameter int SETTLE_CYCLES  = 1024,
   parameter int LOCK_FILTER    = 8,
   parameter int STAGGER_CYCLES = 16,
   parameter int HOLD_CYCLES    = 64,
   parameter int NUM_DOMAINS    = 4,
   parameter int CNT_W          = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   CCC_LOCK,
   input  logic                   INIT_DONE,
   input  logic                   FORCE_RESET,
   output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
   output logic                   CLK_GOOD,
   output logic [2:0]             STATE,
   output logic [7:0]             LOCK_LOSS_CNT
);

   typedef enum logic [2:0] {
      ST_SETTLE     = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_RELEASE    = 3'd2,
      ST_RUN        = 3'd3,
      ST_FAULT_HOLD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [NUM_DOMAINS-1:0] dom_nxt;
   logic [NUM_DOMAINS-1:0] rel_vec;
   logic                   good_nxt;
   logic                   loss_inc;
   logic [1:0]             lock_sync;
   logic [1:0]             init_sync;
   logic                   lock_s;
   logic                   init_s;

   // Lock-loss events are diagnostic only, so the counter sticks at all-ones
   // rather than wrapping back to a misleading small value.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // ---- input synchronizers ----
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_sync <= '0;
         init_sync <= '0;
      end else begin
         lock_sync <= {lock_sync[0], CCC_LOCK};
         init_sync <= {init_sync[0], INIT_DONE};
      end
   end

   assign lock_s = lock_sync[1];
   assign init_s = init_sync[1];

   // Next release pattern: shift one more 1 in from the bottom. When this
   // becomes all ones, the current release is the last one.
   assign rel_vec = NUM_DOMAINS'({DOMAIN_RESET_N, 1'b1});

   // ---- next-state / output decode ----
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dom_nxt   = DOMAIN_RESET_N;
      good_nxt  = CLK_GOOD;
      loss_inc  = 1'b0;

      case (state)
         ST_SETTLE: begin
            // Oscillator warm-up; every input, FORCE_RESET included, is ignored.
            if (cnt == SETTLE_LAST) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            if (FORCE_RESET) begin
               state_nxt = ST_FAULT_HOLD;
               cnt_nxt   = '0;
            end else if (lock_s && init_s) begin
               if (cnt == FILTER_LAST) begin
                  state_nxt = ST_RELEASE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               // Any unqualified cycle restarts the filter window.
               cnt_nxt = '0;
            end
         end

         ST_RELEASE: begin
            if (!lock_s || FORCE_RESET) begin
               state_nxt = ST_FAULT_HOLD;
               cnt_nxt   = '0;
               dom_nxt   = '0;
               good_nxt  = 1'b0;
               loss_inc  = !lock_s;
            end else if (cnt == STAGGER_LAST) begin
               cnt_nxt = '0;
               dom_nxt = rel_vec;
               if (&rel_vec) begin
                  state_nxt = ST_RUN;
                  good_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_RUN: begin
            // INIT_DONE no longer matters once domains are out of reset.
            if (!lock_s || FORCE_RESET) begin
               state_nxt = ST_FAULT_HOLD;
               cnt_nxt   = '0;
               dom_nxt   = '0;
               good_nxt  = 1'b0;
               loss_inc  = !lock_s;
            end
         end

         ST_FAULT_HOLD: begin
            // Lock activity here is not counted; a new FORCE_RESET restarts
            // the full hold window.
            if (FORCE_RESET) begin
               cnt_nxt = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = ST_WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            // Unused encodings recover through a full fault hold.
            state_nxt = ST_FAULT_HOLD;
            cnt_nxt   = '0;
            dom_nxt   = '0;
            good_nxt  = 1'b0;
         end
      endcase
   end

   // ---- state and output registers ----
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state          <= ST_SETTLE;
         cnt            <= '0;
         DOMAIN_RESET_N <= '0;
         CLK_GOOD       <= 1'b0;
         LOCK_LOSS_CNT  <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         DOMAIN_RESET_N <= dom_nxt;
         CLK_GOOD       <= good_nxt;
         if (loss_inc) begin
            LOCK_LOSS_CNT <= sat_inc8(LOCK_LOSS_CNT);
         end
      end
   end

   assign STATE = state;

endmodule
